// File: rtl/fpu_add_sched.sv
// Round-robin scheduler sharing one combinational FP adder between requesters.
// Handles dynamic rounding mode, FSUB via sign flip and a valid/ready response.
module fpu_add_sched #(
  parameter int PARAM_Fp_size       = 32,
  parameter int PARAM_Mantissa_size = 23,
  parameter int PARAM_Exponent_size = 8,
  parameter int NUM_REQ             = 2,
  parameter int TAG_W               = 5,
  parameter int ID_W                = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*PARAM_Fp_size-1:0] req_a,
  input  logic [NUM_REQ*PARAM_Fp_size-1:0] req_b,
  input  logic [NUM_REQ-1:0]         req_sub,
  input  logic [NUM_REQ*3-1:0]       req_rm,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  input  logic [2:0]                 frm,
  output logic [2:0]                 adder_rm,
  output logic [PARAM_Fp_size-1:0]   adder_a,
  output logic [PARAM_Fp_size-1:0]   adder_b,
  input  logic [PARAM_Fp_size-1:0]   adder_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [PARAM_Fp_size-1:0]   rsp_result,
  output logic [ID_W-1:0]            rsp_id,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_illegal_rm
);

  localparam int FP = PARAM_Fp_size;
  localparam logic [FP-1:0] QNAN = {
    1'b0, {PARAM_Exponent_size{1'b1}},
    1'b1, {(PARAM_Mantissa_size-1){1'b0}}
  };

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]  last_q;
  logic [FP-1:0]    op_a_q, op_b_q;
  logic [2:0]       op_rm_q;
  logic             op_ill_q;
  logic [TAG_W-1:0] op_tag_q;
  logic [ID_W-1:0]  op_id_q;

  logic [FP-1:0]    res_q;
  logic             rv_q, ill_q;
  logic [TAG_W-1:0] tag_q;
  logic [ID_W-1:0]  id_q;

  logic             gnt_any;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_en, hs;
  logic [FP-1:0]    sel_a, sel_b;
  logic [2:0]       sel_rm, res_rm;
  logic             sel_ill;

  // Cyclic search starting just after the last granted requester
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end

  assign gnt_en = (state_q == IDLE) ||
                  (state_q == RESP && rsp_ready);
  assign hs     = gnt_en && gnt_any;

  assign sel_a   = req_a[gnt_idx*FP +: FP];
  assign sel_b   = req_b[gnt_idx*FP +: FP] ^
                   {req_sub[gnt_idx], {(FP-1){1'b0}}};
  assign sel_rm  = req_rm[gnt_idx*3 +: 3];
  assign res_rm  = (sel_rm == 3'b111) ? frm : sel_rm;
  assign sel_ill = (res_rm > 3'd4);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = hs ? EXEC : IDLE;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = hs ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q   <= ID_W'(NUM_REQ-1);
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_rm_q  <= '0;
      op_ill_q <= 1'b0;
      op_tag_q <= '0;
      op_id_q  <= '0;
    end else if (hs) begin
      last_q   <= gnt_idx;
      op_a_q   <= sel_a;
      op_b_q   <= sel_b;
      op_rm_q  <= res_rm;
      op_ill_q <= sel_ill;
      op_tag_q <= req_tag[gnt_idx*TAG_W +: TAG_W];
      op_id_q  <= gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rv_q  <= 1'b0;
      res_q <= '0;
      ill_q <= 1'b0;
      tag_q <= '0;
      id_q  <= '0;
    end else if (state_q == EXEC) begin
      rv_q  <= 1'b1;
      res_q <= op_ill_q ? QNAN : adder_out;
      ill_q <= op_ill_q;
      tag_q <= op_tag_q;
      id_q  <= op_id_q;
    end else if (state_q == RESP && rsp_ready) begin
      rv_q  <= 1'b0;
    end
  end

  assign adder_a        = op_a_q;
  assign adder_b        = op_b_q;
  assign adder_rm       = op_rm_q;
  assign rsp_valid      = rv_q;
  assign rsp_result     = res_q;
  assign rsp_illegal_rm = ill_q;
  assign rsp_tag        = tag_q;
  assign rsp_id         = id_q;

endmodule
